// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and strobe in,
// registered status and result out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder step per clock, LSB first, with a
// single carry flop. Result and carry-out are held in dedicated registers.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] a_sh_d;
  logic [WIDTH-1:0] b_sh_d;
  logic [WIDTH-1:0] psum_d;
  logic [CW-1:0]    cnt_d;
  logic             c_d;
  logic [1:0]       fa;
  logic             accept;
  logic             last_bit;

  // Returns {carry, sum} of a one-bit full adder.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  always_comb begin
    fa       = full_add(a_sh_q[0], b_sh_q[0], c_q);
    a_sh_d   = a_sh_q >> 1;
    b_sh_d   = b_sh_q >> 1;
    psum_d   = {fa[0], psum_q[WIDTH-1:1]};
    c_d      = fa[1];
    cnt_d    = cnt_q + CW'(1);
    last_bit = (cnt_q == CW'(WIDTH - 1));
    accept   = bus.start && (state_q != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b;
            c_q     <= bus.cin;
            cnt_q   <= '0;
            psum_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_d;
          b_sh_q <= b_sh_d;
          psum_q <= psum_d;
          c_q    <= c_d;
          cnt_q  <= cnt_d;
          // The last bit lands straight in the output registers, so the
          // result is visible together with the done pulse.
          if (last_bit) begin
            sum_q   <= psum_d;
            cout_q  <= c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random bench for serial_adder at WIDTH=8 and WIDTH=2, checked
// against plain integer addition.
module tb_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision sum; low w bits are sum, bit w is carry-out.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_done_excl8", 64'(bus8.busy & bus8.done), 64'd0);
      check("busy_done_excl2", 64'(bus2.busy & bus2.done), 64'd0);
    end
  end

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input string tag);
    logic [32:0] e;
    int lat, nb;
    e = ref_add({24'd0, a}, {24'd0, b}, ci);
    bus8.a = a; bus8.b = b; bus8.cin = ci; bus8.start = 1'b1;
    @(posedge clk); #1 bus8.start = 1'b0;
    lat = 0; nb = 0;
    while (lat < 40) begin
      @(negedge clk);
      if (bus8.done) break;
      if (bus8.busy) nb++;
      @(posedge clk);
      lat++;
    end
    check({tag, "_done"}, 64'(bus8.done), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'd8);
    check({tag, "_busycyc"}, 64'(nb), 64'd8);
    check({tag, "_sum"}, 64'(bus8.sum), 64'(e[7:0]));
    check({tag, "_cout"}, 64'(bus8.cout), 64'(e[8]));
    @(negedge clk);
    check({tag, "_donefall"}, 64'(bus8.done), 64'd0);
  endtask

  task automatic do_op2(input logic [1:0] a, input logic [1:0] b, input logic ci);
    logic [32:0] e;
    int lat;
    e = ref_add({30'd0, a}, {30'd0, b}, ci);
    bus2.a = a; bus2.b = b; bus2.cin = ci; bus2.start = 1'b1;
    @(posedge clk); #1 bus2.start = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (bus2.done) break;
      @(posedge clk);
      lat++;
    end
    check("rnd2_lat", 64'(lat), 64'd2);
    check("rnd2_sum", 64'(bus2.sum), 64'(e[1:0]));
    check("rnd2_cout", 64'(bus2.cout), 64'(e[2]));
    @(negedge clk);
  endtask

  initial begin
    int n, n2, npulse, at;
    logic [7:0] s_cap;
    logic c_cap;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus8.busy), 64'd0);
    check("rst_done", 64'(bus8.done), 64'd0);
    check("rst_sum", 64'(bus8.sum), 64'd0);
    check("rst_cout", 64'(bus8.cout), 64'd0);
    check("rst_sum2", 64'(bus2.sum), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);

    do_op8(8'h5A, 8'h3C, 1'b0, "t1");
    check("t1_const_sum", 64'(bus8.sum), 64'h96);
    do_op8(8'hFF, 8'h01, 1'b0, "t2a");
    check("t2a_const", 64'({bus8.cout, bus8.sum}), 64'h100);
    do_op8(8'hFF, 8'hFF, 1'b1, "t2b");
    check("t2b_const", 64'({bus8.cout, bus8.sum}), 64'h1FF);
    do_op8(8'h00, 8'h00, 1'b0, "zero");
    do_op8(8'h00, 8'h00, 1'b1, "cinonly");

    // start during RUN is ignored
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1 bus8.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus8.a = 8'hAA; bus8.b = 8'h55; bus8.start = 1'b1;
    @(posedge clk); #1 bus8.start = 1'b0;
    npulse = 0; at = -1; s_cap = '0; c_cap = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) begin npulse++; at = i; s_cap = bus8.sum; c_cap = bus8.cout; end
      @(posedge clk);
    end
    check("ign_pulses", 64'(npulse), 64'd1);
    check("ign_at", 64'(at), 64'd5);
    check("ign_sum", 64'(s_cap), 64'h30);
    check("ign_cout", 64'(c_cap), 64'd0);
    @(negedge clk);

    // reset in the middle of an operation
    bus8.a = 8'h0F; bus8.b = 8'hF0; bus8.cin = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1 bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus8.busy), 64'd0);
    check("arst_done", 64'(bus8.done), 64'd0);
    check("arst_sum", 64'(bus8.sum), 64'd0);
    check("arst_cout", 64'(bus8.cout), 64'd0);
    npulse = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus8.done) npulse++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus8.done) npulse++;
    end
    check("arst_nodone", 64'(npulse), 64'd0);
    do_op8(8'h01, 8'h01, 1'b0, "arst_restart");
    check("arst_restart_const", 64'(bus8.sum), 64'h02);

    // back-to-back with start held high
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1 bus8.a = 8'h7F; bus8.b = 8'h01;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (bus8.done) break;
      @(posedge clk);
      n++;
    end
    check("b2b_first_lat", 64'(n), 64'd8);
    check("b2b_first", 64'({bus8.cout, bus8.sum}), 64'h100);
    n2 = 0;
    while (n2 < 40) begin
      @(posedge clk);
      n2++;
      @(negedge clk);
      if (bus8.done) break;
      check("b2b_hold_sum", 64'(bus8.sum), 64'h00);
      check("b2b_busy", 64'(bus8.busy), 64'd1);
    end
    bus8.start = 1'b0;
    check("b2b_spacing", 64'(n2), 64'd9);
    check("b2b_second", 64'({bus8.cout, bus8.sum}), 64'h080);
    @(negedge clk);
    check("b2b_idle_busy", 64'(bus8.busy), 64'd0);
    check("b2b_idle_done", 64'(bus8.done), 64'd0);

    for (int i = 0; i < 500; i++)
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), "rnd8");
    for (int i = 0; i < 500; i++)
      do_op2(2'($urandom), 2'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
